// File: rtl/tsip_timing_parser.sv
// tsip_timing_parser
// Frames TSIP packets from the UART byte stream and removes DLE stuffing.
// Extracts the UTC date/time from the Primary Timing Packet and presents it
// with a one-cycle strobe. A malformed or wrong-length timing packet
// produces a one-cycle error strobe instead.
module tsip_timing_parser #(
  parameter logic [7:0]  PKT_ID  = 8'h8F,
  parameter logic [7:0]  SUBCODE = 8'hAB,
  parameter int unsigned PKT_LEN = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_packet_dv,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic [7:0]  o_timing_flag,
  output logic        o_frame_err
);

  localparam logic [7:0] DLE     = 8'h10;
  localparam logic [7:0] ETX     = 8'h03;
  localparam logic [4:0] CNT_MAX = 5'd31;
  localparam logic [4:0] LEN_CNT = 5'(PKT_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ID,
    S_DATA,
    S_DATA_DLE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] r_id;
  logic [4:0] r_cnt;
  logic       r_match;

  logic [7:0] sh_flag;
  logic [7:0] sh_sec;
  logic [7:0] sh_min;
  logic [7:0] sh_hour;
  logic [7:0] sh_day;
  logic [7:0] sh_month;
  logic [7:0] sh_year_hi;
  logic [7:0] sh_year_lo;

  // End-of-packet decisions are registered once before reaching the outputs
  logic commit_req;
  logic err_req;

  logic       latch_id;
  logic       payload_we;
  logic [7:0] payload_byte;
  logic       end_pkt;
  logic       resync;

  // Framing state register; idle cycles (no i_rx_dv) leave it untouched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-byte control strobes
  always_comb begin
    state_nxt    = state;
    latch_id     = 1'b0;
    payload_we   = 1'b0;
    payload_byte = i_rx_byte;
    end_pkt      = 1'b0;
    resync       = 1'b0;
    if (i_rx_dv) begin
      case (state)
        S_IDLE: begin
          if (i_rx_byte == DLE) begin
            state_nxt = S_WAIT_ID;
          end
        end
        S_WAIT_ID: begin
          if ((i_rx_byte == DLE) || (i_rx_byte == ETX)) begin
            state_nxt = S_IDLE;
          end else begin
            latch_id  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (i_rx_byte == DLE) begin
            state_nxt = S_DATA_DLE;
          end else begin
            payload_we = 1'b1;
          end
        end
        S_DATA_DLE: begin
          if (i_rx_byte == DLE) begin
            payload_we   = 1'b1;
            payload_byte = DLE;
            state_nxt    = S_DATA;
          end else if (i_rx_byte == ETX) begin
            end_pkt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            // A lone DLE followed by a non-framing byte is treated as the
            // start of a fresh packet whose ID is this byte
            resync    = 1'b1;
            latch_id  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Packet ID, payload counter, match flag and end-of-packet requests
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id       <= 8'd0;
      r_cnt      <= 5'd0;
      r_match    <= 1'b0;
      commit_req <= 1'b0;
      err_req    <= 1'b0;
    end else begin
      commit_req <= 1'b0;
      err_req    <= 1'b0;
      if (latch_id) begin
        r_id    <= i_rx_byte;
        r_cnt   <= 5'd0;
        r_match <= (i_rx_byte == PKT_ID);
      end
      if (payload_we) begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 5'd1;
        end
        if ((r_cnt == 5'd0) && (payload_byte != SUBCODE)) begin
          r_match <= 1'b0;
        end
      end
      if (end_pkt && r_match) begin
        if (r_cnt == LEN_CNT) begin
          commit_req <= 1'b1;
        end else begin
          err_req <= 1'b1;
        end
      end
      if (resync) begin
        err_req <= 1'b1;
      end
    end
  end

  // Shadow time fields, written by unstuffed data index of the wanted packet
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_flag    <= 8'd0;
      sh_sec     <= 8'd0;
      sh_min     <= 8'd0;
      sh_hour    <= 8'd0;
      sh_day     <= 8'd0;
      sh_month   <= 8'd0;
      sh_year_hi <= 8'd0;
      sh_year_lo <= 8'd0;
    end else if (payload_we && (r_id == PKT_ID)) begin
      case (r_cnt)
        5'd9:    sh_flag    <= payload_byte;
        5'd10:   sh_sec     <= payload_byte;
        5'd11:   sh_min     <= payload_byte;
        5'd12:   sh_hour    <= payload_byte;
        5'd13:   sh_day     <= payload_byte;
        5'd14:   sh_month   <= payload_byte;
        5'd15:   sh_year_hi <= payload_byte;
        5'd16:   sh_year_lo <= payload_byte;
        default: ;
      endcase
    end
  end

  // Output registers: commit shadow fields together with the strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_packet_dv   <= 1'b0;
      o_frame_err   <= 1'b0;
      o_year        <= 16'd0;
      o_month       <= 8'd0;
      o_day         <= 8'd0;
      o_hour        <= 8'd0;
      o_minutes     <= 8'd0;
      o_seconds     <= 8'd0;
      o_timing_flag <= 8'd0;
    end else begin
      o_packet_dv <= commit_req;
      o_frame_err <= err_req;
      if (commit_req) begin
        o_year        <= {sh_year_hi, sh_year_lo};
        o_month       <= sh_month;
        o_day         <= sh_day;
        o_hour        <= sh_hour;
        o_minutes     <= sh_min;
        o_seconds     <= sh_sec;
        o_timing_flag <= sh_flag;
      end
    end
  end

endmodule

// File: tb/tb_tsip_timing_parser.sv
// tb_tsip_timing_parser
// Directed test-plan sequences plus randomized frames, checked against a
// packet-level reference model that unstuffs bytes into a queue.
module tb_tsip_timing_parser;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] PID = 8'h8F;
  localparam logic [7:0] SUB = 8'hAB;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_packet_dv;
  logic [15:0] o_year;
  logic [7:0]  o_month;
  logic [7:0]  o_day;
  logic [7:0]  o_hour;
  logic [7:0]  o_minutes;
  logic [7:0]  o_seconds;
  logic [7:0]  o_timing_flag;
  logic        o_frame_err;

  tsip_timing_parser dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .o_packet_dv  (o_packet_dv),
    .o_year       (o_year),
    .o_month      (o_month),
    .o_day        (o_day),
    .o_hour       (o_hour),
    .o_minutes    (o_minutes),
    .o_seconds    (o_seconds),
    .o_timing_flag(o_timing_flag),
    .o_frame_err  (o_frame_err)
  );

  initial forever #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  bit random_gaps = 1'b0;

  logic [7:0] data_q[$];

  // Reference model: framing flags plus the unstuffed body of the current packet
  logic [7:0] body_q[$];
  logic [7:0] m_id;
  bit         m_sync;
  bit         m_in_body;
  bit         m_esc;
  bit         exp_dv;
  bit         exp_err;
  logic [15:0] exp_year;
  logic [7:0]  exp_month, exp_day, exp_hour, exp_min, exp_sec, exp_flag;

  function automatic void modelReset();
    body_q.delete();
    m_id      = 8'd0;
    m_sync    = 1'b0;
    m_in_body = 1'b0;
    m_esc     = 1'b0;
    exp_dv    = 1'b0;
    exp_err   = 1'b0;
    exp_year  = 16'd0;
    exp_month = 8'd0;
    exp_day   = 8'd0;
    exp_hour  = 8'd0;
    exp_min   = 8'd0;
    exp_sec   = 8'd0;
    exp_flag  = 8'd0;
  endfunction

  // A packet is judged on its whole unstuffed body once ETX arrives
  function automatic void modelFinish();
    if ((m_id == PID) && ((body_q.size() == 0) || (body_q[0] == SUB))) begin
      if (body_q.size() == 17) begin
        exp_dv    = 1'b1;
        exp_flag  = body_q[9];
        exp_sec   = body_q[10];
        exp_min   = body_q[11];
        exp_hour  = body_q[12];
        exp_day   = body_q[13];
        exp_month = body_q[14];
        exp_year  = {body_q[15], body_q[16]};
      end else begin
        exp_err = 1'b1;
      end
    end
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    if (!m_in_body) begin
      if (m_sync) begin
        m_sync = 1'b0;
        if ((b != DLE) && (b != ETX)) begin
          m_id = b;
          body_q.delete();
          m_in_body = 1'b1;
        end
      end else if (b == DLE) begin
        m_sync = 1'b1;
      end
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (b == DLE) begin
        body_q.push_back(DLE);
      end else if (b == ETX) begin
        m_in_body = 1'b0;
        modelFinish();
      end else begin
        exp_err = 1'b1;
        m_id = b;
        body_q.delete();
      end
    end else if (b == DLE) begin
      m_esc = 1'b1;
    end else begin
      body_q.push_back(b);
    end
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic checkStrobes(input string tag);
    checkVal({tag, ".packet_dv"}, {15'd0, o_packet_dv}, {15'd0, exp_dv});
    checkVal({tag, ".frame_err"}, {15'd0, o_frame_err}, {15'd0, exp_err});
  endtask

  task automatic checkOutput(input string tag);
    checkStrobes(tag);
    checkVal({tag, ".year"},  o_year, exp_year);
    checkVal({tag, ".month"}, {8'd0, o_month}, {8'd0, exp_month});
    checkVal({tag, ".day"},   {8'd0, o_day}, {8'd0, exp_day});
    checkVal({tag, ".hour"},  {8'd0, o_hour}, {8'd0, exp_hour});
    checkVal({tag, ".min"},   {8'd0, o_minutes}, {8'd0, exp_min});
    checkVal({tag, ".sec"},   {8'd0, o_seconds}, {8'd0, exp_sec});
    checkVal({tag, ".flag"},  {8'd0, o_timing_flag}, {8'd0, exp_flag});
  endtask

  // One received byte: nothing may change on the sampling edge, results
  // appear one edge later, then strobes stay low through the idle gap
  task automatic applyStimulus(input logic [7:0] b);
    int gap;
    @(negedge i_clk);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(posedge i_clk);
    #1;
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    checkOutput("sample");
    modelByte(b);
    @(negedge i_clk);
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'($urandom);
    @(posedge i_clk);
    #1;
    checkOutput("result");
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    gap = random_gaps ? int'($urandom_range(18, 0)) : 0;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
      checkStrobes("gap");
    end
  endtask

  task automatic sendBody(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      if (data_q[k] == DLE) applyStimulus(DLE);
      applyStimulus(data_q[k]);
    end
  endtask

  task automatic sendFrame(input logic [7:0] id);
    applyStimulus(DLE);
    applyStimulus(id);
    sendBody(0, data_q.size() - 1);
    applyStimulus(DLE);
    applyStimulus(ETX);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_rx_dv = 1'b0;
    @(posedge i_clk);
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  function automatic void buildNominal(input logic [7:0] sec);
    data_q = '{8'hAB, 8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h10, 8'h00, 8'h12,
               8'h03, sec, 8'h2D, 8'h0C, 8'h0F, 8'h07, 8'h07, 8'hE8};
  endfunction

  function automatic logic [7:0] randByte();
    if ($urandom_range(3, 0) == 0) return DLE;
    return 8'($urandom);
  endfunction

  function automatic void buildRandom(input int n);
    data_q.delete();
    for (int k = 0; k < n; k++) begin
      data_q.push_back((k == 0) ? SUB : randByte());
    end
  endfunction

  initial begin
    int kind;
    logic [7:0] id;
    i_rst     = 1'b1;
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'd0;
    modelReset();
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("por");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Nominal packet, back-to-back bytes
    buildNominal(8'h1E);
    sendFrame(PID);
    checkVal("nominal.year",  o_year, 16'd2024);
    checkVal("nominal.month", {8'd0, o_month}, 16'd7);
    checkVal("nominal.day",   {8'd0, o_day}, 16'd15);
    checkVal("nominal.hour",  {8'd0, o_hour}, 16'd12);
    checkVal("nominal.min",   {8'd0, o_minutes}, 16'd45);
    checkVal("nominal.sec",   {8'd0, o_seconds}, 16'd30);
    checkVal("nominal.flag",  {8'd0, o_timing_flag}, 16'd3);

    // Same packet with idle gaps between bytes
    random_gaps = 1'b1;
    sendFrame(PID);

    // Stuffed seconds field
    buildNominal(8'h10);
    sendFrame(PID);
    checkVal("stuffed.sec", {8'd0, o_seconds}, 16'd16);

    // Wrong subcode and wrong ID leave outputs untouched
    buildNominal(8'h22);
    data_q[0] = 8'hAC;
    sendFrame(PID);
    data_q[0] = SUB;
    sendFrame(8'h47);
    checkVal("nomatch.sec", {8'd0, o_seconds}, 16'd16);

    // Short packet, then a valid one
    buildNominal(8'h05);
    void'(data_q.pop_back());
    sendFrame(PID);
    checkVal("short.sec", {8'd0, o_seconds}, 16'd16);
    buildNominal(8'h05);
    sendFrame(PID);
    checkVal("after_short.sec", {8'd0, o_seconds}, 16'd5);

    // Resync on a lone DLE followed by a new ID
    applyStimulus(DLE);
    applyStimulus(PID);
    applyStimulus(SUB);
    applyStimulus(8'h00);
    buildNominal(8'h33);
    sendFrame(PID);
    checkVal("resync.sec", {8'd0, o_seconds}, 16'd51);

    // Overlong packet saturates the counter and fails the length check
    buildRandom(40);
    sendFrame(PID);
    checkVal("long.sec", {8'd0, o_seconds}, 16'd51);

    // Reset in the middle of a packet
    buildNominal(8'h1E);
    applyStimulus(DLE);
    applyStimulus(PID);
    sendBody(0, 7);
    doReset();
    sendBody(8, 16);
    applyStimulus(DLE);
    applyStimulus(ETX);
    checkVal("midreset.year", o_year, 16'd0);
    sendFrame(PID);
    checkVal("postreset.year", o_year, 16'd2024);

    // Randomized frames of every flavour
    for (int f = 0; f < 60; f++) begin
      random_gaps = ($urandom_range(1, 0) == 1);
      kind = int'($urandom_range(5, 0));
      case (kind)
        0: begin
          buildRandom(17);
          sendFrame(PID);
        end
        1: begin
          buildRandom(17);
          data_q[0] = randByte();
          if (data_q[0] == SUB) data_q[0] = 8'hAC;
          sendFrame(PID);
        end
        2: begin
          id = 8'($urandom);
          if ((id == DLE) || (id == ETX) || (id == PID)) id = 8'h47;
          buildRandom(17);
          sendFrame(id);
        end
        3: begin
          buildRandom(int'($urandom_range(35, 0)));
          sendFrame(PID);
        end
        4: begin
          repeat ($urandom_range(8, 1)) applyStimulus(randByte());
        end
        default: begin
          applyStimulus(DLE);
          applyStimulus(PID);
          applyStimulus(SUB);
          applyStimulus(8'($urandom_range(255, 20)));
          buildRandom(17);
          sendFrame(PID);
        end
      endcase
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
